// File: rtl/fully_serial_iir_synth.sv
// Fully serial 8-tap all-pole IIR synthesis filter:
//   y[n] = x[n] - sum(k=1..8) a_k * y[n-k]
// One shared multiplier and one accumulator walk the eight feedback taps over an
// 8-clock frame; the new sample is formed, quantised and saturated at count 7.
// Data formats: x sfix33_En31, y sfix16_En15, a_k sfix16_En14.
// Build option: define IIR_SYNTH_ROUND_EN for round-half-up quantisation.
// Without it, quantisation truncates toward -inf.
module fully_serial_iir_synth #(
  parameter logic signed [15:0] COEFF1 = 16'shE000,
  parameter logic signed [15:0] COEFF2 = 16'sh0000,
  parameter logic signed [15:0] COEFF3 = 16'sh0000,
  parameter logic signed [15:0] COEFF4 = 16'sh0000,
  parameter logic signed [15:0] COEFF5 = 16'sh0000,
  parameter logic signed [15:0] COEFF6 = 16'sh0000,
  parameter logic signed [15:0] COEFF7 = 16'sh0000,
  parameter logic signed [15:0] COEFF8 = 16'sh0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic signed [32:0] filter_in,
  output logic signed [15:0] filter_out,
  output logic               ce_out
);

  localparam int unsigned IN_W    = 33;
  localparam int unsigned OUT_W   = 16;
  localparam int unsigned COEFF_W = 16;
  localparam int unsigned PROD_W  = 32;
  localparam int unsigned SH_W    = 34;
  localparam int unsigned ACC_W   = 37;
  localparam int unsigned DIFF_W  = 38;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TAPS    = 8;

  logic        [CNT_W-1:0]   cur_count;
  logic                      phase_7_c;
  logic signed [IN_W-1:0]    x_reg;
  logic signed [ACC_W-1:0]   acc;
  // y_hist[0] holds y[n-1], y_hist[TAPS-1] holds y[n-8]
  logic signed [OUT_W-1:0]   y_hist [TAPS];

  logic signed [COEFF_W-1:0] coeff_sel_c;
  logic signed [OUT_W-1:0]   y_sel_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [SH_W-1:0]    prod_sh_c;
  logic signed [ACC_W-1:0]   prod_ext_c;
  logic signed [ACC_W-1:0]   fb_c;
  logic signed [DIFF_W-1:0]  diff_c;
  logic signed [OUT_W-1:0]   y_new_c;

  assign phase_7_c = (cur_count == CNT_W'(7)) && clk_enable;

  // Coefficient for the tap served this clock (tap = cur_count + 1)
  always_comb begin
    coeff_sel_c = COEFF1;
    case (cur_count)
      3'd0:    coeff_sel_c = COEFF1;
      3'd1:    coeff_sel_c = COEFF2;
      3'd2:    coeff_sel_c = COEFF3;
      3'd3:    coeff_sel_c = COEFF4;
      3'd4:    coeff_sel_c = COEFF5;
      3'd5:    coeff_sel_c = COEFF6;
      3'd6:    coeff_sel_c = COEFF7;
      default: coeff_sel_c = COEFF8;
    endcase
  end

  assign y_sel_c = y_hist[cur_count];

  // Shared multiplier: En15 x En14 = En29, realigned to En31 and widened to the accumulator
  assign prod_c     = y_sel_c * coeff_sel_c;
  assign prod_sh_c  = {prod_c, 2'b00};
  assign prod_ext_c = ACC_W'(prod_sh_c);

  // Full feedback sum, valid at count 7 when the last tap joins the accumulated seven
  assign fb_c   = acc + prod_ext_c;
  assign diff_c = DIFF_W'(x_reg) - DIFF_W'(fb_c);

`ifdef IIR_SYNTH_ROUND_EN
  localparam int unsigned Q_W = 39;
  logic signed [Q_W-1:0] rnd_c;
  logic signed [Q_W-1:0] q_c;
  // Round half up: add half an output LSB before dropping 16 fraction bits
  assign rnd_c = Q_W'(diff_c) + Q_W'(39'sd32768);
  assign q_c   = rnd_c >>> 16;
`else
  localparam int unsigned Q_W = DIFF_W;
  logic signed [Q_W-1:0] q_c;
  // Truncate toward -inf by dropping 16 fraction bits
  assign q_c = diff_c >>> 16;
`endif

  localparam logic signed [Q_W-1:0] SAT_MAX = Q_W'(32767);
  localparam logic signed [Q_W-1:0] SAT_MIN = Q_W'(-32768);

  // Clip the quantised sample into the sfix16_En15 range
  always_comb begin
    y_new_c = q_c[OUT_W-1:0];
    if (q_c > SAT_MAX) begin
      y_new_c = 16'sh7FFF;
    end else if (q_c < SAT_MIN) begin
      y_new_c = 16'sh8000;
    end
  end

  // Frame counter, accumulator, history, input capture and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_count  <= CNT_W'(7);
      acc        <= '0;
      x_reg      <= '0;
      filter_out <= '0;
      ce_out     <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
        y_hist[i] <= '0;
      end
    end else begin
      ce_out <= phase_7_c;
      if (clk_enable) begin
        cur_count <= cur_count + CNT_W'(1);
        if (cur_count == CNT_W'(0)) begin
          acc <= prod_ext_c;
        end else if (cur_count != CNT_W'(7)) begin
          acc <= fb_c;
        end
        if (phase_7_c) begin
          filter_out <= y_new_c;
          x_reg      <= filter_in;
          y_hist[0]  <= y_new_c;
          for (int i = 1; i < int'(TAPS); i++) begin
            y_hist[i] <= y_hist[i-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fully_serial_iir_synth.sv
// Scoreboard bench for fully_serial_iir_synth: three instances (default taps,
// all-zero taps, single tap 8) driven by per-frame stimulus; a frame-level
// difference-equation model predicts each output sample.
module tb_fully_serial_iir_synth;

  logic               clk;
  logic               reset;
  logic               clk_enable;
  logic signed [32:0] fi [3];
  logic signed [15:0] fo [3];
  logic               ce [3];

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;

  // Reference model state
  int     coef_m [3][8];
  longint hist_m [3][8];
  longint xreg_m [3];
  int     exp_q  [3][$];
  int     m_count = 7;
  bit     rst_edge = 1'b0;
  bit     pushed_edge = 1'b0;
  logic signed [15:0] prev_fo [3];

  fully_serial_iir_synth u_dut_a (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .filter_in(fi[0]), .filter_out(fo[0]), .ce_out(ce[0]));

  fully_serial_iir_synth #(
    .COEFF1(16'sh0000)
  ) u_dut_z (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .filter_in(fi[1]), .filter_out(fo[1]), .ce_out(ce[1]));

  fully_serial_iir_synth #(
    .COEFF1(16'sh0000), .COEFF8(16'shE000)
  ) u_dut_m (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .filter_in(fi[2]), .filter_out(fo[2]), .ce_out(ce[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One output sample of y[n] = x[n] - sum a_k y[n-k], quantised and clipped
  function automatic int model_step(int d, longint x);
    longint fb;
    longint diff;
    longint q;
    fb = 0;
    for (int k = 0; k < 8; k++) fb += longint'(coef_m[d][k]) * hist_m[d][k] * 4;
    diff = x - fb;
`ifdef IIR_SYNTH_ROUND_EN
    q = (diff + 32768) >>> 16;
`else
    q = diff >>> 16;
`endif
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    for (int k = 7; k > 0; k--) hist_m[d][k] = hist_m[d][k-1];
    hist_m[d][0] = q;
    return int'(q);
  endfunction

  // Model advance: one output per frame, input captured at the frame boundary
  always @(posedge clk) begin
    rst_edge    = !reset;
    pushed_edge = 1'b0;
    if (!reset) begin
      m_count = 7;
      for (int d = 0; d < 3; d++) begin
        xreg_m[d] = 0;
        for (int k = 0; k < 8; k++) hist_m[d][k] = 0;
        exp_q[d].delete();
      end
    end else if (clk_enable) begin
      if (m_count == 7) begin
        pushed_edge = 1'b1;
        for (int d = 0; d < 3; d++) begin
          exp_q[d].push_back(model_step(d, xreg_m[d]));
          xreg_m[d] = longint'(fi[d]);
        end
      end
      m_count = (m_count + 1) % 8;
    end
  end

  // Monitor: compare each presented output against the scoreboard
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 3; d++) begin
      if (rst_edge) begin
        n_cmp++;
        if (fo[d] !== 16'sd0 || ce[d] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset_state dut%0d: filter_out=%0d ce_out=%b, required 0/0", d, fo[d], ce[d]);
        end
      end else begin
        n_cmp++;
        if (ce[d] !== pushed_edge) begin
          n_bad++;
          $display("FAIL ce_timing dut%0d: ce_out=%b, required %b", d, ce[d], pushed_edge);
        end
        if (ce[d] === 1'b1) begin
          n_cmp++;
          if (exp_q[d].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out dut%0d: filter_out=%0d with empty scoreboard", d, fo[d]);
          end else begin
            int e;
            e = exp_q[d].pop_front();
            n_out++;
            if (int'(fo[d]) != e) begin
              n_bad++;
              $display("FAIL sample dut%0d: filter_out=%0d, required %0d", d, fo[d], e);
            end
          end
        end else begin
          n_cmp++;
          if (fo[d] !== prev_fo[d]) begin
            n_bad++;
            $display("FAIL hold dut%0d: filter_out changed %0d -> %0d without ce_out", d, prev_fo[d], fo[d]);
          end
        end
      end
      prev_fo[d] = fo[d];
    end
  end

  // Present one input per instance until the DUT frame boundary captures it
  task automatic frame(input longint x0, input longint x1, input longint x2, input int gap);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      fi[0] = 33'(x0);
      fi[1] = 33'(x1);
      fi[2] = 33'(x2);
      clk_enable = ($urandom_range(99) >= 32'(gap));
      if (m_count == 7 && clk_enable) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: frame boundary not reached, required within 400 cycles");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clk_enable = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic longint rnd_x();
    logic signed [32:0] r;
    r = {1'($urandom), $urandom};
    return longint'(r) >>> $urandom_range(10, 0);
  endfunction

  initial begin
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 8; k++) coef_m[d][k] = 0;
    coef_m[0][0] = -8192;
    coef_m[2][7] = -8192;
    reset = 1'b0;
    clk_enable = 1'b0;
    for (int d = 0; d < 3; d++) fi[d] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Impulse / quantiser positive / multi-tap impulse
    frame(64'sh040000000, 98304, 64'sh040000000, 0);
    for (int i = 0; i < 24; i++) frame(0, 98304, 0, 0);

    // Saturation both ways, negative quantiser case
    for (int i = 0; i < 10; i++) frame(64'sh060000000, -98304, rnd_x(), 0);
    for (int i = 0; i < 10; i++) frame(-64'sh060000000, -98304, rnd_x(), 0);

    // Impulse again with enable gaps
    do_reset();
    frame(64'sh040000000, 98304, 64'sh040000000, 30);
    for (int i = 0; i < 20; i++) frame(0, -98304, 0, 30);

    // Reset in the middle of the impulse tail
    do_reset();
    frame(64'sh040000000, 98304, 64'sh040000000, 0);
    frame(0, 0, 0, 0);
    frame(0, 0, 0, 0);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
        @(negedge clk);
        clk_enable = 1'b1;
        for (int d = 0; d < 3; d++) fi[d] = '0;
        if (m_count == 3) begin
          reset = 1'b0;
          hit = 1'b1;
        end
      end
      @(negedge clk);
      reset = 1'b1;
    end
    for (int i = 0; i < 6; i++) frame(0, 0, 0, 0);

    // Random traffic with gaps
    for (int i = 0; i < 40; i++) frame(rnd_x(), rnd_x(), rnd_x(), 20);
    for (int i = 0; i < 2; i++) frame(0, 0, 0, 0);
    repeat (4) @(negedge clk);

    n_cmp++;
    if (n_out < 300) begin
      n_bad++;
      $display("FAIL output_count: %0d samples compared, required at least 300", n_out);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
